// File: rtl/vsru_chain_scheduler.sv
// rtl/vsru_chain_scheduler.sv - round-robin chain scheduler feeding the vector reduce unit
//
// Purpose: arbitrates MAX_CHAINS requester chains frame by frame (round robin,
// no preemption) and forwards the granted chain's beats, tagged with its chain
// id and per-chain reduce-mode byte, to the reduce unit with one cycle latency.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_eof          per-chain beat valid / last beat of frame
//   req_vector                 all chains' lanes; chain c owns lanes c*N..c*N+N-1
//   req_ready                  per-chain beat accept (only the granted chain)
//   cfg_we/cfg_chain/cfg_data  reduce-mode byte write
//   cfg_busy                   a write to the streaming chain is held pending
//   valid_out..vector_out      registered beat stream to the reduce unit
//   frames_done                wrapping count of completed frames
module vsru_chain_scheduler #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  localparam int CW        = $clog2(MAX_CHAINS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MAX_CHAINS-1:0] req_valid,
  input  logic [MAX_CHAINS-1:0] req_eof,
  input  logic [DATA_WIDTH-1:0] req_vector [MAX_CHAINS*N-1:0],
  output logic [MAX_CHAINS-1:0] req_ready,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_chain,
  input  logic [7:0]            cfg_data,
  output logic                  cfg_busy,
  output logic                  valid_out,
  output logic                  eof_out,
  output logic [CW-1:0]         chainId_out,
  output logic [7:0]            conf_out,
  output logic [DATA_WIDTH-1:0] vector_out [N-1:0],
  output logic [15:0]           frames_done
);

  localparam int VW = $clog2(MAX_CHAINS * N);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         grant_q, grant_d;
  logic [CW-1:0]         last_grant_q, last_grant_d;
  logic [CW-1:0]         rr_pick, rr_cand;
  logic                  rr_found;
  logic                  xfer, xfer_eof;
  logic [7:0]            conf_q [MAX_CHAINS];
  logic                  pend_q;
  logic [CW-1:0]         pend_chain_q;
  logic [7:0]            pend_data_q;
  logic                  cfg_ok, cfg_hit_grant;
  logic [DATA_WIDTH-1:0] lanes [N];

  // First requesting chain strictly after the last frame's owner, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_cand  = '0;
    rr_pick  = grant_q;
    for (int i = 1; i <= MAX_CHAINS; i++) begin
      rr_cand = CW'((int'(last_grant_q) + i) % MAX_CHAINS);
      if (!rr_found && req_valid[rr_cand]) begin
        rr_pick  = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < N; l++) begin
      lanes[l] = req_vector[VW'(int'(grant_q) * N + l)];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    xfer         = 1'b0;
    xfer_eof     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = rr_pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        req_ready[grant_q] = 1'b1;
        xfer = req_valid[grant_q];
        if (xfer && req_eof[grant_q]) begin
          xfer_eof     = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(MAX_CHAINS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A write aimed at the chain currently streaming is parked so the frame in
  // flight keeps one reduce mode throughout; it lands on that chain's eof edge.
  // An eof in the same cycle as the write still counts as mid-frame.
  assign cfg_ok        = (int'(cfg_chain) < MAX_CHAINS);
  assign cfg_hit_grant = (state_q == STREAM) && (grant_q == cfg_chain);
  assign cfg_busy      = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        conf_q[c] <= '0;
      end
      pend_q       <= 1'b0;
      pend_chain_q <= '0;
      pend_data_q  <= '0;
    end else begin
      if (cfg_we && !pend_q && cfg_ok) begin
        if (cfg_hit_grant) begin
          pend_q       <= 1'b1;
          pend_chain_q <= cfg_chain;
          pend_data_q  <= cfg_data;
        end else begin
          conf_q[cfg_chain] <= cfg_data;
        end
      end
      if (pend_q && xfer_eof && (grant_q == pend_chain_q)) begin
        conf_q[pend_chain_q] <= pend_data_q;
        pend_q               <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      chainId_out <= '0;
      conf_out    <= '0;
      frames_done <= '0;
      for (int l = 0; l < N; l++) begin
        vector_out[l] <= '0;
      end
    end else begin
      valid_out <= xfer;
      eof_out   <= xfer && req_eof[grant_q];
      if (xfer) begin
        chainId_out <= grant_q;
        conf_out    <= conf_q[grant_q];
        for (int l = 0; l < N; l++) begin
          vector_out[l] <= lanes[l];
        end
      end
      if (xfer_eof) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end

endmodule
